cp0_unit: RTL and testbench
===========================

CP0_UNIT -- requirements
Module: cp0_unit

Interface
REQ-001 SHALL have parameter: HW_INT_NUM, 6, number of hardware interrupt lines (1..6), mapped to Cause.IP[2+i].
REQ-002 SHALL have parameter: EX_ENTRY, 32'hBFC00380, exception entry vector.
REQ-003 SHALL have port: clk  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port: reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have ports: wb_ex in 1 exception commit; wb_excode in 5 ExcCode; wb_bd in 1 instruction is in a delay slot; wb_pc in 32; wb_badvaddr in 32.
REQ-006 SHALL have port: eret_flush  input  1  ERET commit.
REQ-007 SHALL have ports: mtc0_we in 1; mtc0_addr in 8 ({rd,sel}); mtc0_wdata in 32; mfc0_addr in 8; mfc0_rdata out 32.
REQ-008 SHALL have port: hw_int  input  HW_INT_NUM  level-sensitive external interrupts.
REQ-009 SHALL have outputs: int_pending 1; pipeline_flush 1; flush_pc 32; epc_out 32; status_out 32.

Function
REQ-010 SHALL implement these registers ({rd,sel}): BadVAddr {8,0}, Count {9,0}, Compare {11,0}, Status {12,0}, Cause {13,0}, EPC {14,0}.
REQ-011 Status SHALL hold BEV bit22 constant 1, IM[15:8] RW, EXL bit1, IE bit0 RW; all other bits SHALL read 0.
REQ-012 Cause SHALL hold BD bit31, TI bit30, IP[15:10] hardware, IP[9:8] software RW, ExcCode[6:2]; all other bits SHALL read 0.
REQ-013 Write priority per cycle SHALL be wb_ex > eret_flush > mtc0_we; a lower-priority write in the same cycle SHALL be dropped.
REQ-014 On wb_ex with EXL=0, the unit SHALL set EPC to wb_bd ? wb_pc-4 : wb_pc and Cause.BD to wb_bd; with EXL=1, EPC and BD SHALL be left unchanged.
REQ-015 On wb_ex, the unit SHALL set EXL to 1 and ExcCode to wb_excode unconditionally.
REQ-016 On wb_ex with excode 4 (AdEL) or 5 (AdES), the unit SHALL load BadVAddr from wb_badvaddr; other codes SHALL leave BadVAddr unchanged.
REQ-017 On eret_flush, the unit SHALL clear EXL.
REQ-018 pipeline_flush SHALL be registered, asserting for exactly one cycle after wb_ex or eret_flush.
REQ-019 flush_pc SHALL be registered alongside pipeline_flush: EX_ENTRY for an exception, EPC for ERET.
REQ-020 Cause.IP[2+i] SHALL sample hw_int[i] every cycle; IP bits at or above 2+HW_INT_NUM SHALL read 0, except that IP[7] SHALL be hw_int[5] OR TI.
REQ-021 int_pending SHALL be combinational: IE & ~EXL & |(IP & IM).
REQ-022 mfc0_rdata SHALL be combinational; an unimplemented address SHALL read 0.
REQ-023 A same-cycle mtc0 to the mfc0_addr register SHALL return the old value.

Reset
REQ-024 When reset=0, the unit SHALL clear Status to 32'h0040_0000, and clear Cause, EPC, BadVAddr, Count, Compare, the tick toggle, pipeline_flush and flush_pc to 0.
REQ-025 Reset SHALL override wb_ex, eret_flush and mtc0_we in the same cycle.

Configuration
REQ-026 Macro CP0_TIMER_EN SHALL control the timer.
- Defined: Count SHALL increment once every two cycles, wrapping at 2^32-1 to 0.
- Defined: TI SHALL set when Count increments to a value equal to Compare.
- Defined: an mtc0 to Compare SHALL clear TI, and SHALL win over a same-cycle set.
- Defined: an mtc0 to Count SHALL override the increment.
- Undefined: Count, Compare and TI SHALL read 0 and writes to them SHALL be ignored.

Structure
REQ-027 Package cp0_pkg SHALL hold the register address constants, ExcCode constants (Int=0, AdEL=4, AdES=5, Sys=8, Bp=9, RI=10, Ov=12) and the default entry vector.
REQ-028 The Count/Compare/TI logic SHALL be a sub-module cp0_timer, instantiated only under CP0_TIMER_EN.

Verification
REQ-029 Scenario: reset=0 for 2 cycles -> mfc0 Status = 32'h0040_0000; Cause = 0; pipeline_flush = 0.
REQ-030 Scenario: wb_ex, excode=4, bd=1, pc=32'hBFC0_0100, badvaddr=32'h1 -> next cycle EPC=32'hBFC0_00FC, BD=1, EXL=1, BadVAddr=32'h1, pipeline_flush=1, flush_pc=32'hBFC0_0380.
REQ-031 Scenario: second wb_ex while EXL=1, pc=32'h100 -> EPC unchanged, ExcCode updated; then eret_flush -> EXL=0, flush_pc=EPC.
REQ-032 Scenario: mtc0 Status=32'h0000_0401, hw_int[0]=1 -> int_pending=1; set EXL via wb_ex -> int_pending=0.
REQ-033 Scenario (CP0_TIMER_EN): Compare=10, Count=0 -> TI=1 after 20 cycles; mtc0 Compare=50 -> TI=0 next cycle.
REQ-034 Scenario: wb_ex and mtc0 Status=32'h1 in the same cycle -> IE stays 0; EXL=1.

Source files
------------

// File: rtl/cp0_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cp0_pkg : CP0 register addresses, exception codes, entry vector.   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package cp0_pkg;

  function automatic logic [7:0] cp0_addr(input logic [4:0] rd, input logic [2:0] sel);
    return {rd, sel};
  endfunction

  localparam logic [7:0] c_ADDR_BADVADDR = cp0_addr(5'd8, 3'd0);
  localparam logic [7:0] c_ADDR_COUNT    = cp0_addr(5'd9, 3'd0);
  localparam logic [7:0] c_ADDR_COMPARE  = cp0_addr(5'd11, 3'd0);
  localparam logic [7:0] c_ADDR_STATUS   = cp0_addr(5'd12, 3'd0);
  localparam logic [7:0] c_ADDR_CAUSE    = cp0_addr(5'd13, 3'd0);
  localparam logic [7:0] c_ADDR_EPC      = cp0_addr(5'd14, 3'd0);

  localparam logic [4:0] c_EXC_INT  = 5'd0;
  localparam logic [4:0] c_EXC_ADEL = 5'd4;
  localparam logic [4:0] c_EXC_ADES = 5'd5;
  localparam logic [4:0] c_EXC_SYS  = 5'd8;
  localparam logic [4:0] c_EXC_BP   = 5'd9;
  localparam logic [4:0] c_EXC_RI   = 5'd10;
  localparam logic [4:0] c_EXC_OV   = 5'd12;

  localparam logic [31:0] c_EX_ENTRY_DEFAULT = 32'hBFC0_0380;

endpackage
`default_nettype wire

// File: rtl/cp0_timer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cp0_timer : Count/Compare timer, only built under CP0_TIMER_EN.    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module cp0_timer (
  input  logic        clk,
  input  logic        reset,
  input  logic        count_we,
  input  logic        compare_we,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        ti
);

  logic        r_tick;
  logic [31:0] r_count;
  logic [31:0] r_compare;
  logic        r_ti;
  logic [31:0] w_count_inc;

  assign w_count_inc = r_count + 32'd1;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_tick    <= 1'b0;
      r_count   <= '0;
      r_compare <= '0;
      r_ti      <= 1'b0;
    end else begin
      r_tick <= ~r_tick;
      if (count_we)
        r_count <= wdata;
      else if (r_tick)
        r_count <= w_count_inc;
      if (compare_we)
        r_compare <= wdata;
      // A Compare write acknowledges the interrupt and beats a same-cycle match.
      if (compare_we)
        r_ti <= 1'b0;
      else if (!count_we && r_tick && (w_count_inc == r_compare))
        r_ti <= 1'b1;
    end
  end

  assign count   = r_count;
  assign compare = r_compare;
  assign ti      = r_ti;

endmodule
`default_nettype wire

// File: rtl/cp0_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cp0_unit : MIPS-style CP0 (Status/Cause/EPC/BadVAddr, exceptions,  |
// |            ERET, interrupts). Timer enabled by macro CP0_TIMER_EN. |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module cp0_unit
  import cp0_pkg::*;
#(
  parameter int          HW_INT_NUM = 6,
  parameter logic [31:0] EX_ENTRY   = c_EX_ENTRY_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wb_ex,
  input  logic [4:0]            wb_excode,
  input  logic                  wb_bd,
  input  logic [31:0]           wb_pc,
  input  logic [31:0]           wb_badvaddr,
  input  logic                  eret_flush,
  input  logic                  mtc0_we,
  input  logic [7:0]            mtc0_addr,
  input  logic [31:0]           mtc0_wdata,
  input  logic [7:0]            mfc0_addr,
  output logic [31:0]           mfc0_rdata,
  input  logic [HW_INT_NUM-1:0] hw_int,
  output logic                  int_pending,
  output logic                  pipeline_flush,
  output logic [31:0]           flush_pc,
  output logic [31:0]           epc_out,
  output logic [31:0]           status_out
);

  logic [7:0]  r_im;
  logic        r_exl;
  logic        r_ie;
  logic        r_bd;
  logic [4:0]  r_excode;
  logic [1:0]  r_ip_sw;
  logic [5:0]  r_ip_hw;
  logic [31:0] r_epc;
  logic [31:0] r_badvaddr;
  logic        r_flush;
  logic [31:0] r_flush_pc;

  logic [5:0]  w_hw_ext;
  logic        w_mtc0_ok;
  logic [31:0] w_count;
  logic [31:0] w_compare;
  logic        w_ti;
  logic [7:0]  w_ip;
  logic [31:0] w_status;
  logic [31:0] w_cause;
  logic [31:0] w_rdata;

  generate
    for (genvar i = 0; i < 6; i++) begin : g_hw_ext
      if (i < HW_INT_NUM) begin : g_line
        assign w_hw_ext[i] = hw_int[i];
      end else begin : g_tie
        assign w_hw_ext[i] = 1'b0;
      end
    end
  endgenerate

  // mtc0 loses to any exception or ERET committing in the same cycle.
  assign w_mtc0_ok = mtc0_we & ~wb_ex & ~eret_flush;

`ifdef CP0_TIMER_EN
  cp0_timer u_timer (
    .clk        (clk),
    .reset      (reset),
    .count_we   (w_mtc0_ok && (mtc0_addr == c_ADDR_COUNT)),
    .compare_we (w_mtc0_ok && (mtc0_addr == c_ADDR_COMPARE)),
    .wdata      (mtc0_wdata),
    .count      (w_count),
    .compare    (w_compare),
    .ti         (w_ti)
  );
`else
  assign w_count   = '0;
  assign w_compare = '0;
  assign w_ti      = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_im       <= '0;
      r_exl      <= 1'b0;
      r_ie       <= 1'b0;
      r_bd       <= 1'b0;
      r_excode   <= '0;
      r_ip_sw    <= '0;
      r_ip_hw    <= '0;
      r_epc      <= '0;
      r_badvaddr <= '0;
      r_flush    <= 1'b0;
      r_flush_pc <= '0;
    end else begin
      r_ip_hw <= w_hw_ext;
      if (wb_ex) begin
        // Nested exceptions keep the original return point.
        if (!r_exl) begin
          r_epc <= wb_bd ? (wb_pc - 32'd4) : wb_pc;
          r_bd  <= wb_bd;
        end
        r_exl    <= 1'b1;
        r_excode <= wb_excode;
        if ((wb_excode == c_EXC_ADEL) || (wb_excode == c_EXC_ADES))
          r_badvaddr <= wb_badvaddr;
      end else if (eret_flush) begin
        r_exl <= 1'b0;
      end else if (w_mtc0_ok) begin
        case (mtc0_addr)
          c_ADDR_STATUS: begin
            r_im <= mtc0_wdata[15:8];
            r_ie <= mtc0_wdata[0];
          end
          c_ADDR_CAUSE: r_ip_sw <= mtc0_wdata[9:8];
          c_ADDR_EPC:   r_epc   <= mtc0_wdata;
          default: ;
        endcase
      end
      r_flush <= wb_ex | eret_flush;
      if (wb_ex)
        r_flush_pc <= EX_ENTRY;
      else if (eret_flush)
        r_flush_pc <= r_epc;
    end
  end

  assign w_ip     = {r_ip_hw[5] | w_ti, r_ip_hw[4:0], r_ip_sw};
  assign w_status = {9'b0, 1'b1, 6'b0, r_im, 6'b0, r_exl, r_ie};
  assign w_cause  = {r_bd, w_ti, 14'b0, w_ip, 1'b0, r_excode, 2'b0};

  always_comb begin
    w_rdata = '0;
    case (mfc0_addr)
      c_ADDR_BADVADDR: w_rdata = r_badvaddr;
      c_ADDR_COUNT:    w_rdata = w_count;
      c_ADDR_COMPARE:  w_rdata = w_compare;
      c_ADDR_STATUS:   w_rdata = w_status;
      c_ADDR_CAUSE:    w_rdata = w_cause;
      c_ADDR_EPC:      w_rdata = r_epc;
      default:         w_rdata = '0;
    endcase
  end

  assign mfc0_rdata     = w_rdata;
  assign int_pending    = r_ie & ~r_exl & (|(w_ip & r_im));
  assign pipeline_flush = r_flush;
  assign flush_pc       = r_flush_pc;
  assign epc_out        = r_epc;
  assign status_out     = w_status;

endmodule
`default_nettype wire

// File: tb/tb_cp0_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_cp0_unit : directed scenarios plus random traffic vs. a model.  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_cp0_unit;
  import cp0_pkg::*;

  localparam int HWN = 6;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_ex;
  logic [4:0]  wb_excode;
  logic        wb_bd;
  logic [31:0] wb_pc;
  logic [31:0] wb_badvaddr;
  logic        eret_flush;
  logic        mtc0_we;
  logic [7:0]  mtc0_addr;
  logic [31:0] mtc0_wdata;
  logic [7:0]  mfc0_addr;
  logic [31:0] mfc0_rdata;
  logic [HWN-1:0] hw_int;
  logic        int_pending;
  logic        pipeline_flush;
  logic [31:0] flush_pc;
  logic [31:0] epc_out;
  logic [31:0] status_out;

  cp0_unit #(.HW_INT_NUM(HWN), .EX_ENTRY(32'hBFC0_0380)) dut (
    .clk(clk), .reset(reset), .wb_ex(wb_ex), .wb_excode(wb_excode), .wb_bd(wb_bd),
    .wb_pc(wb_pc), .wb_badvaddr(wb_badvaddr), .eret_flush(eret_flush),
    .mtc0_we(mtc0_we), .mtc0_addr(mtc0_addr), .mtc0_wdata(mtc0_wdata),
    .mfc0_addr(mfc0_addr), .mfc0_rdata(mfc0_rdata), .hw_int(hw_int),
    .int_pending(int_pending), .pipeline_flush(pipeline_flush), .flush_pc(flush_pc),
    .epc_out(epc_out), .status_out(status_out)
  );

  always #10 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Reference model: architectural words, updated once per clock from the rules.
  logic [31:0] m_status, m_cause, m_epc, m_badv, m_count, m_compare, m_fpc;
  logic [5:0]  m_iphw;
  logic        m_ti, m_tick, m_flush, m_valid;

  function automatic logic [31:0] m_cause_rd();
    logic [31:0] v;
    v = m_cause;
    v[14:10] = m_iphw[4:0];
    v[15] = m_iphw[5] | m_ti;
    v[30] = m_ti;
    return v;
  endfunction

  function automatic logic [31:0] m_read(input logic [7:0] a);
    case (a)
      c_ADDR_BADVADDR: return m_badv;
      c_ADDR_COUNT:    return m_count;
      c_ADDR_COMPARE:  return m_compare;
      c_ADDR_STATUS:   return m_status;
      c_ADDR_CAUSE:    return m_cause_rd();
      c_ADDR_EPC:      return m_epc;
      default:         return 32'h0;
    endcase
  endfunction

  function automatic logic m_int();
    logic [31:0] c;
    c = m_cause_rd();
    return m_status[0] & ~m_status[1] & (|(c[15:8] & m_status[15:8]));
  endfunction

  task automatic model_update();
    logic ok;
    logic inc, cw, pw;
    logic [31:0] nc;
    ok = mtc0_we & ~wb_ex & ~eret_flush;
    m_valid = 1'b1;
    if (!reset) begin
      m_status = 32'h0040_0000; m_cause = 0; m_iphw = 0; m_epc = 0; m_badv = 0;
      m_count = 0; m_compare = 0; m_ti = 0; m_tick = 0; m_flush = 0; m_fpc = 0;
      return;
    end
`ifdef CP0_TIMER_EN
    inc = m_tick;
    m_tick = ~m_tick;
    cw = ok && (mtc0_addr == c_ADDR_COUNT);
    pw = ok && (mtc0_addr == c_ADDR_COMPARE);
    nc = cw ? mtc0_wdata : m_count + {31'b0, inc};
    if (pw) m_ti = 1'b0;
    else if (!cw && inc && nc == m_compare) m_ti = 1'b1;
    if (pw) m_compare = mtc0_wdata;
    m_count = nc;
`else
    inc = 1'b0; cw = 1'b0; pw = 1'b0; nc = 32'h0;
`endif
    if (wb_ex) begin
      if (!m_status[1]) begin
        m_epc = wb_bd ? wb_pc - 32'd4 : wb_pc;
        m_cause[31] = wb_bd;
      end
      m_status[1] = 1'b1;
      m_cause[6:2] = wb_excode;
      if (wb_excode == 5'd4 || wb_excode == 5'd5) m_badv = wb_badvaddr;
      m_flush = 1'b1;
      m_fpc = 32'hBFC0_0380;
    end else if (eret_flush) begin
      m_status[1] = 1'b0;
      m_flush = 1'b1;
      m_fpc = m_epc;
    end else begin
      m_flush = 1'b0;
      if (ok) begin
        case (mtc0_addr)
          c_ADDR_STATUS: m_status = (m_status & ~32'h0000_FF01) | (mtc0_wdata & 32'h0000_FF01);
          c_ADDR_CAUSE:  m_cause  = (m_cause & ~32'h0000_0300) | (mtc0_wdata & 32'h0000_0300);
          c_ADDR_EPC:    m_epc    = mtc0_wdata;
          default: ;
        endcase
      end
    end
    m_iphw = hw_int;
  endtask

  // Inputs are set just after an edge; combinational outputs checked before the next edge.
  task automatic cycle();
    #1;
    if (m_valid) begin
      check("mfc0_rdata", mfc0_rdata, m_read(mfc0_addr));
      check("int_pending", 32'(int_pending), 32'(m_int()));
      check("status_out", status_out, m_status);
      check("epc_out", epc_out, m_epc);
    end
    @(posedge clk);
    model_update();
    #1;
    check("pipeline_flush", 32'(pipeline_flush), 32'(m_flush));
    if (m_flush) check("flush_pc", flush_pc, m_fpc);
  endtask

  task automatic idle();
    reset = 1'b1; wb_ex = 1'b0; wb_excode = 5'd0; wb_bd = 1'b0; wb_pc = 32'h0;
    wb_badvaddr = 32'h0; eret_flush = 1'b0; mtc0_we = 1'b0; mtc0_addr = 8'h0; mtc0_wdata = 32'h0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] v);
    mfc0_addr = a;
    #1;
    v = mfc0_rdata;
  endtask

  task automatic do_mtc0(input logic [7:0] a, input logic [31:0] d);
    idle(); mtc0_we = 1'b1; mtc0_addr = a; mtc0_wdata = d;
    cycle();
    idle();
  endtask

  logic [7:0] addr_pool [8];
  logic [4:0] exc_pool [7];

  initial begin
    logic [31:0] v;
    int k;
    addr_pool = '{c_ADDR_BADVADDR, c_ADDR_COUNT, c_ADDR_COMPARE, c_ADDR_STATUS,
                  c_ADDR_CAUSE, c_ADDR_EPC, 8'h61, 8'h00};
    exc_pool = '{c_EXC_INT, c_EXC_ADEL, c_EXC_ADES, c_EXC_SYS, c_EXC_BP, c_EXC_RI, c_EXC_OV};
    m_valid = 1'b0;
    idle(); reset = 1'b0; hw_int = '0; mfc0_addr = c_ADDR_STATUS;
    #1;
    cycle(); cycle();
    check("rst_flush", 32'(pipeline_flush), 32'd0);
    check("rst_flush_pc", flush_pc, 32'd0);
    idle();
    rd(c_ADDR_STATUS, v); check("rst_status", v, 32'h0040_0000);
    rd(c_ADDR_CAUSE, v);  check("rst_cause", v, 32'h0);

    // Address error in a delay slot.
    wb_ex = 1'b1; wb_excode = 5'd4; wb_bd = 1'b1; wb_pc = 32'hBFC0_0100; wb_badvaddr = 32'h1;
    cycle();
    check("ex_flush", 32'(pipeline_flush), 32'd1);
    check("ex_flush_pc", flush_pc, 32'hBFC0_0380);
    idle();
    rd(c_ADDR_EPC, v);      check("ex_epc", v, 32'hBFC0_00FC);
    rd(c_ADDR_CAUSE, v);    check("ex_cause", v, 32'h8000_0010);
    rd(c_ADDR_BADVADDR, v); check("ex_badvaddr", v, 32'h1);
    cycle();
    check("flush_one_cycle", 32'(pipeline_flush), 32'd0);

    // Nested exception keeps EPC, then ERET.
    wb_ex = 1'b1; wb_excode = 5'd8; wb_pc = 32'h100;
    cycle();
    idle();
    rd(c_ADDR_EPC, v);   check("nest_epc", v, 32'hBFC0_00FC);
    rd(c_ADDR_CAUSE, v); check("nest_cause", v, 32'h8000_0020);
    eret_flush = 1'b1;
    cycle();
    check("eret_flush_pc", flush_pc, 32'hBFC0_00FC);
    idle();
    rd(c_ADDR_STATUS, v); check("eret_status", v, 32'h0040_0000);

    // Interrupt pending, masked by EXL.
    hw_int = 6'b000001;
    do_mtc0(c_ADDR_STATUS, 32'h0000_0401);
    #1; check("int_on", 32'(int_pending), 32'd1);
    wb_ex = 1'b1; wb_excode = 5'd0; wb_pc = 32'h200;
    cycle();
    idle();
    #1; check("int_masked_exl", 32'(int_pending), 32'd0);
    eret_flush = 1'b1; cycle(); idle();
    hw_int = '0;
    do_mtc0(c_ADDR_STATUS, 32'h0);

    // Exception beats same-cycle mtc0.
    wb_ex = 1'b1; wb_excode = 5'd12; mtc0_we = 1'b1; mtc0_addr = c_ADDR_STATUS; mtc0_wdata = 32'h1;
    cycle();
    idle();
    rd(c_ADDR_STATUS, v); check("prio_status", v, 32'h0040_0002);
    eret_flush = 1'b1; cycle(); idle();

`ifdef CP0_TIMER_EN
    do_mtc0(c_ADDR_COMPARE, 32'd10);
    do_mtc0(c_ADDR_COUNT, 32'd0);
    mfc0_addr = c_ADDR_CAUSE;
    k = 0;
    while (k < 40 && !m_ti) begin
      cycle();
      k++;
    end
    check("timer_ti_cycles_ok", 32'((k >= 19) && (k <= 21)), 32'd1);
    rd(c_ADDR_CAUSE, v); check("timer_ti_set", 32'(v[30]), 32'd1);
    do_mtc0(c_ADDR_COMPARE, 32'd50);
    rd(c_ADDR_CAUSE, v); check("timer_ti_clr", 32'(v[30]), 32'd0);
`else
    rd(c_ADDR_COUNT, v); check("no_timer_count", v, 32'h0);
    do_mtc0(c_ADDR_COMPARE, 32'd10);
    rd(c_ADDR_COMPARE, v); check("no_timer_compare", v, 32'h0);
`endif

    // Random traffic.
    for (int i = 0; i < 800; i++) begin
      idle();
      reset       = ($urandom_range(0, 99) != 0);
      wb_ex       = ($urandom_range(0, 9) == 0);
      wb_excode   = exc_pool[$urandom_range(0, 6)];
      wb_bd       = $urandom_range(0, 1) == 1;
      wb_pc       = $urandom() & 32'hFFFF_FFFC;
      wb_badvaddr = $urandom();
      eret_flush  = ($urandom_range(0, 9) == 0);
      mtc0_we     = ($urandom_range(0, 2) == 0);
      mtc0_addr   = addr_pool[$urandom_range(0, 7)];
      mtc0_wdata  = $urandom();
      mfc0_addr   = addr_pool[$urandom_range(0, 7)];
      if ($urandom_range(0, 3) == 0) hw_int = HWN'($urandom());
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
